// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control FSM with memory handshake stalls.
// Optional ADDI support (ADDIEX/ADDIWB states) is enabled by defining MIPS_MC_CTRL_ADDI_EN.
module mips_mc_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic [3:0] State,
  output logic       IllegalOp
);
  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] RTWB   = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] JUMP   = 4'd9;
  localparam logic [3:0] ADDIEX = 4'd10;
  localparam logic [3:0] ADDIWB = 4'd11;
`ifdef MIPS_MC_CTRL_ADDI_EN
  localparam logic ADDI = 1'b1;
`else
  localparam logic ADDI = 1'b0;
`endif
  logic [3:0] state_q, state_d;
  assign State = state_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  always_comb begin
    state_d     = FETCH;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IllegalOp   = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady & ~reset;
        PCWrite = MemReady & ~reset;
        state_d = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB   = 2'b11;
        state_d   = (Op == 6'h00) ? EXEC :
                    (Op == 6'h23 || Op == 6'h2B) ? MEMADR :
                    (Op == 6'h04) ? BRANCH :
                    (Op == 6'h02) ? JUMP :
                    (ADDI && Op == 6'h08) ? ADDIEX : FETCH;
        IllegalOp = (state_d == FETCH);
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == 6'h23) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = MemReady ? MEMWB : MEMRD;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = MemReady ? FETCH : MEMWR;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = RTWB;
      end
      RTWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef MIPS_MC_CTRL_ADDI_EN
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: RegWrite = 1'b1;
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: spec-level model checked every cycle plus directed literal checks.
module tb_mips_mc_ctrl;
`ifdef MIPS_MC_CTRL_ADDI_EN
  localparam bit ADDI = 1'b1;
`else
  localparam bit ADDI = 1'b0;
`endif
  logic       clock, reset, MemReady;
  logic [5:0] Op;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic       ALUSrcA, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, RegWrite, MemtoReg, IllegalOp;
  logic [3:0] State;
  int n_cmp = 0, n_fail = 0, m_st = 0;
  mips_mc_ctrl dut (
    .clock(clock), .reset(reset), .Op(Op), .MemReady(MemReady),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .State(State), .IllegalOp(IllegalOp)
  );
  wire [16:0] dut_vec = {ALUOp, ALUSrcA, ALUSrcB, PCWrite, PCWriteCond, PCSource,
                         IorD, MemRead, MemWrite, IRWrite, RegDst, RegWrite, MemtoReg, IllegalOp};
  initial clock = 1'b0;
  always #5 clock = ~clock;
  function automatic bit legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02 ||
           (ADDI && op == 6'h08);
  endfunction
  function automatic int nxt(input int st, input logic [5:0] op, input logic rdy);
    case (st)
      0: return rdy ? 1 : 0;
      1: return op == 6'h00 ? 6 : (op == 6'h23 || op == 6'h2B) ? 2 : op == 6'h04 ? 8 :
                op == 6'h02 ? 9 : (ADDI && op == 6'h08) ? 10 : 0;
      2: return op == 6'h23 ? 3 : 5;
      3: return rdy ? 4 : 3;
      5: return rdy ? 0 : 5;
      6: return 7;
      10: return ADDI ? 11 : 0;
      default: return 0;
    endcase
  endfunction
  function automatic logic [16:0] model_out(input int st, input logic [5:0] op,
                                            input logic rdy, input logic rst);
    logic [1:0] aop = 0, srcb = 0, psrc = 0;
    logic srca = 0, pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, rd = 0, rw = 0, m2r = 0, ill = 0;
    case (st)
      0: begin mr = 1; srcb = 1; irw = rdy && !rst; pcw = rdy && !rst; end
      1: begin srcb = 3; ill = !legal(op); end
      2: begin srca = 1; srcb = 2; end
      3: begin mr = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; iord = 1; end
      6: begin srca = 1; aop = 2; end
      7: begin rw = 1; rd = 1; end
      8: begin srca = 1; aop = 1; pcwc = 1; psrc = 1; end
      9: begin pcw = 1; psrc = 2; end
      10: if (ADDI) begin srca = 1; srcb = 2; end
      11: if (ADDI) rw = 1;
      default: ;
    endcase
    return {aop, srca, srcb, pcw, pcwc, psrc, iord, mr, mw, irw, rd, rw, m2r, ill};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clock or posedge reset)
    if (reset) m_st <= 0;
    else       m_st <= nxt(m_st, Op, MemReady);
  always @(negedge clock) begin
    chk("model_state", {28'd0, State}, m_st);
    chk("model_outs", {15'd0, dut_vec}, {15'd0, model_out(m_st, Op, MemReady, reset)});
  end
  task automatic go(input logic [5:0] op, input logic rdy, input int exp_st);
    @(negedge clock);
    #1;
    Op = op;
    MemReady = rdy;
    #1;
    chk("state", {28'd0, State}, exp_st);
  endtask
  initial begin
    reset = 1'b0;
    Op = 6'h00;
    MemReady = 1'b0;
    #1 reset = 1'b1;
    #1 MemReady = 1'b1;
    #1;
    chk("rst_state", {28'd0, State}, 0);
    chk("rst_irwrite", {31'd0, IRWrite}, 0);
    chk("rst_pcwrite", {31'd0, PCWrite}, 0);
    chk("rst_memread", {31'd0, MemRead}, 1);
    MemReady = 1'b0;
    @(negedge clock);
    #1 reset = 1'b0;
    go(6'h00, 1, 0); go(6'h00, 1, 1); go(6'h00, 1, 6);
    chk("exec_aluop", {30'd0, ALUOp}, 2);
    go(6'h00, 1, 7);
    chk("rtwb_regwrite", {31'd0, RegWrite}, 1);
    chk("rtwb_regdst", {31'd0, RegDst}, 1);
    go(6'h23, 1, 0); go(6'h23, 1, 1); go(6'h23, 1, 2);
    go(6'h23, 0, 3); go(6'h23, 0, 3); go(6'h23, 0, 3); go(6'h23, 1, 3);
    go(6'h23, 1, 4);
    chk("memwb_memtoreg", {31'd0, MemtoReg}, 1);
    go(6'h2B, 1, 0); go(6'h2B, 1, 1); go(6'h2B, 1, 2); go(6'h2B, 1, 5);
    chk("memwr_memwrite", {31'd0, MemWrite}, 1);
    chk("memwr_iord", {31'd0, IorD}, 1);
    chk("memwr_regwrite", {31'd0, RegWrite}, 0);
    go(6'h04, 1, 0); go(6'h04, 1, 1); go(6'h04, 1, 8);
    chk("branch_aluop", {30'd0, ALUOp}, 1);
    chk("branch_pcwc", {31'd0, PCWriteCond}, 1);
    go(6'h02, 1, 0); go(6'h02, 1, 1); go(6'h02, 1, 9);
    chk("jump_pcsource", {30'd0, PCSource}, 2);
    chk("jump_pcwrite", {31'd0, PCWrite}, 1);
    go(6'h3F, 1, 0); go(6'h3F, 1, 1);
    chk("illegal_3f", {31'd0, IllegalOp}, 1);
    go(6'h08, 1, 0); go(6'h08, 1, 1);
`ifdef MIPS_MC_CTRL_ADDI_EN
    chk("addi_legal", {31'd0, IllegalOp}, 0);
    go(6'h08, 1, 10); go(6'h08, 1, 11);
    chk("addiwb_regwrite", {31'd0, RegWrite}, 1);
`else
    chk("addi_illegal", {31'd0, IllegalOp}, 1);
`endif
    go(6'h2B, 1, 0); go(6'h2B, 1, 1); go(6'h2B, 1, 2); go(6'h2B, 0, 5); go(6'h2B, 0, 5);
    reset = 1'b1;
    #1;
    chk("async_rst_state", {28'd0, State}, 0);
    chk("async_rst_memwrite", {31'd0, MemWrite}, 0);
    Op = 6'h00;
    MemReady = 1'b0;
    @(negedge clock);
    #1 reset = 1'b0;
    go(6'h00, 1, 0);
    chk("resume_irwrite", {31'd0, IRWrite}, 1);
    go(6'h00, 1, 1); go(6'h00, 1, 6); go(6'h00, 1, 7); go(6'h00, 0, 0);
    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 clock  in  1  single rising-edge clock.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 Op  in  6  instruction opcode field from the IR.
REQ-004 MemReady  in  1  memory handshake; 1 = current access completes this cycle.
REQ-005 ALUOp  out  2  to ALU control: 00 add, 01 subtract, 10 use funct field.
REQ-006 ALUSrcA  out  1  0 = PC, 1 = register A.
REQ-007 ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-008 PCWrite, PCWriteCond  out  1 each  unconditional / branch-conditional PC update.
REQ-009 PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-010 IorD, MemRead, MemWrite, IRWrite  out  1 each  memory address select and strobes.
REQ-011 RegDst, RegWrite, MemtoReg  out  1 each  register-file write control.
REQ-012 State  out  4  current state encoding, for debug.
REQ-013 IllegalOp  out  1  high in DECODE when Op is not recognised.

Function
REQ-014 The FSM SHALL have states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-015 Every output not listed for a state SHALL be 0 in that state.
REQ-016 FETCH outputs:
- MemRead=1, ALUSrcB=01, ALUOp=00.
- IRWrite=1 and PCWrite=1 only while MemReady=1.
- Next state: DECODE if MemReady=1, else stay in FETCH.
REQ-017 DECODE: ALUSrcB=11, ALUOp=00. Next state by Op:
- 0x00 -> EXEC
- 0x23 or 0x2B -> MEMADR
- 0x04 -> BRANCH
- 0x02 -> JUMP
- 0x08 -> ADDIEX (only when ADDI is enabled, see REQ-029)
- any other Op -> FETCH with IllegalOp=1.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: MEMRD if Op=0x23, else MEMWR.
REQ-019 MEMRD: MemRead=1, IorD=1. Next state: MEMWB if MemReady=1, else stay.
REQ-020 MEMWR: MemWrite=1, IorD=1. Next state: FETCH if MemReady=1, else stay.
REQ-021 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state: FETCH.
REQ-022 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state: RTWB.
REQ-023 RTWB: RegWrite=1, RegDst=1. Next state: FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next state: FETCH.
REQ-025 JUMP: PCWrite=1, PCSource=10. Next state: FETCH.
REQ-026 Outputs SHALL be combinational decodes of State (plus MemReady where stated), settling in the same cycle; the only storage is the 4-bit state register.

Reset
REQ-027 While reset=1, State SHALL be FETCH immediately (asynchronous, no clock edge needed); all strobes other than MemRead SHALL be 0; IRWrite and PCWrite SHALL be forced to 0 regardless of MemReady.
REQ-028 Reset asserted in any state, including a MEMRD/MEMWR wait, SHALL abandon the operation; after release the FSM SHALL start in FETCH on the next clock edge.

Configuration
REQ-029 Macro MIPS_MC_CTRL_ADDI_EN:
- Defined: ADDIEX (ALUSrcA=1, ALUSrcB=10, ALUOp=00; next ADDIWB) and ADDIWB (RegWrite=1, RegDst=0, MemtoReg=0; next FETCH) exist.
- Undefined: Op 0x08 is illegal; codes 10-11 behave as in REQ-014.

Verification
REQ-030 Reset, then Op=0x00 with MemReady=1 throughout -> State sequence 0,1,6,7,0; ALUOp=10 in EXEC; RegWrite=1 and RegDst=1 in RTWB.
REQ-031 Op=0x23, MemReady=0 for 3 cycles in MEMRD -> FSM holds in state 3 for 3 cycles, then goes 4,0; MemtoReg=1 in MEMWB.
REQ-032 Op=0x2B -> sequence 0,1,2,5,0; MemWrite=1 and IorD=1 in MEMWR; RegWrite stays 0 throughout.
REQ-033 Op=0x04, then 0x02 -> BRANCH shows ALUOp=01 and PCWriteCond=1; JUMP shows PCSource=10 and PCWrite=1.
REQ-034 Op=0x3F in DECODE -> IllegalOp=1 for one cycle, next state FETCH; Op=0x08 -> states 10,11 when the macro is defined, illegal when undefined.
REQ-035 Reset asserted mid-MEMWR with MemReady=0 -> State=0 without a clock edge and MemWrite=0; normal fetch resumes after release.
